img_stream_sequencer: RTL and testbench

Frame sequencer that reads a grayscale image from a pixel memory and drives it into the per_img_* input of the image-processing chain (bilateral filter and siblings) with the vsync/href framing those blocks expect. It turns a single start pulse, or free-running continuous mode, into one or more complete frames. It issues memory reads one cycle ahead of href so that pixels line up with href with no bubbles, and it reports busy/done/frame count to the host.

---
 rtl/img_seq_pkg.sv | 24 ++
 rtl/img_seq_cnt.sv | 37 +++
 rtl/img_stream_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_img_stream_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_seq_pkg.sv
// Shared types and helpers for the image stream sequencer.
package img_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_V_LEAD  = 3'd1,
        S_H_BLANK = 3'd2,
        S_ACTIVE  = 3'd3,
        S_V_TAIL  = 3'd4,
        S_V_GAP   = 3'd5
    } seq_state_t;

    // Number of vsync-high cycles in one complete frame.
    function automatic int unsigned frame_cycles(
        input int unsigned hdisp,
        input int unsigned vdisp,
        input int unsigned hblank,
        input int unsigned vlead,
        input int unsigned vtail
    );
        return vlead + vdisp * (hblank + hdisp) + vtail;
    endfunction

endpackage

// File: rtl/img_seq_cnt.sv
// Loadable down-counter timing each sequencer phase; o_tc marks the last cycle of a phase.
module img_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt_nxt,
    output logic         o_tc
);
    logic [W-1:0] r_cnt;

    // Next count: load wins, otherwise decrement and stick at zero.
    always_comb begin
        o_cnt_nxt = r_cnt;
        if (i_load) begin
            o_cnt_nxt = i_load_val;
        end else if (r_cnt != {W{1'b0}}) begin
            o_cnt_nxt = r_cnt - W'(1);
        end else begin
            o_cnt_nxt = r_cnt;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {W{1'b0}};
        end else begin
            r_cnt <= o_cnt_nxt;
        end
    end

    assign o_tc = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/img_stream_sequencer.sv
// Reads a frame from pixel memory and drives it out with vsync/href framing,
// issuing reads one cycle ahead of href so pixels arrive without bubbles.
module img_stream_sequencer
    import img_seq_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int H_BLANK   = 5,
    parameter int V_LEAD    = 5,
    parameter int V_TAIL    = 1,
    parameter int V_GAP     = 10,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cont,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              per_img_vsync,
    output logic              per_img_href,
    output logic [7:0]        per_img_gray,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);
    localparam int CNT_W = $clog2(IMG_HDISP + V_LEAD + H_BLANK + V_TAIL + V_GAP + 1);
    localparam int ROW_W = $clog2(IMG_VDISP + 1);
    localparam logic [CNT_W-1:0] LD_VLEAD  = CNT_W'(V_LEAD - 1);
    localparam logic [CNT_W-1:0] LD_HBLANK = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] LD_ACTIVE = CNT_W'(IMG_HDISP - 1);
    localparam logic [CNT_W-1:0] LD_VTAIL  = CNT_W'(V_TAIL - 1);
    localparam logic [CNT_W-1:0] LD_VGAP   = CNT_W'(V_GAP - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_VDISP - 1);

    seq_state_t        r_state;
    seq_state_t        w_nstate;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_tc;
    logic [ROW_W-1:0]  r_row;
    logic [ROW_W-1:0]  w_row_nxt;
    logic              r_vsync;
    logic              r_href;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [15:0]       r_frame_cnt;
    logic              w_vsync_nxt;
    logic              w_href_nxt;
    logic              w_done_nxt;
    logic              w_rd_en_nxt;
    logic              w_addr_inc;

    img_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_tc       (w_tc)
    );

    // Next-state, phase-counter load and row bookkeeping.
    always_comb begin
        w_nstate   = r_state;
        w_load     = 1'b0;
        w_load_val = {CNT_W{1'b0}};
        w_row_nxt  = r_row;
        if (r_state == S_IDLE) begin
            if (start && !abort) begin
                w_nstate   = S_V_LEAD;
                w_load     = 1'b1;
                w_load_val = LD_VLEAD;
                w_row_nxt  = {ROW_W{1'b0}};
            end else begin
                w_nstate = S_IDLE;
            end
        end else if (abort) begin
            w_nstate = S_IDLE;
        end else if (w_tc) begin
            w_load = 1'b1;
            case (r_state)
                S_V_LEAD: begin
                    w_nstate   = S_H_BLANK;
                    w_load_val = LD_HBLANK;
                    w_row_nxt  = {ROW_W{1'b0}};
                end
                S_H_BLANK: begin
                    w_nstate   = S_ACTIVE;
                    w_load_val = LD_ACTIVE;
                end
                S_ACTIVE: begin
                    if (r_row == LAST_ROW) begin
                        w_nstate   = S_V_TAIL;
                        w_load_val = LD_VTAIL;
                    end else begin
                        w_nstate   = S_H_BLANK;
                        w_load_val = LD_HBLANK;
                        w_row_nxt  = r_row + ROW_W'(1);
                    end
                end
                S_V_TAIL: begin
                    if (cont) begin
                        w_nstate   = S_V_GAP;
                        w_load_val = LD_VGAP;
                    end else begin
                        w_nstate = S_IDLE;
                        w_load   = 1'b0;
                    end
                end
                S_V_GAP: begin
                    w_nstate   = S_V_LEAD;
                    w_load_val = LD_VLEAD;
                    w_row_nxt  = {ROW_W{1'b0}};
                end
                default: begin
                    w_nstate = S_IDLE;
                    w_load   = 1'b0;
                end
            endcase
        end else begin
            w_nstate = r_state;
        end
    end

    // Outputs are decoded from the state being entered so they are flops aligned with it.
    always_comb begin
        w_vsync_nxt = (w_nstate == S_V_LEAD) || (w_nstate == S_H_BLANK) ||
                      (w_nstate == S_ACTIVE) || (w_nstate == S_V_TAIL);
        w_href_nxt  = (w_nstate == S_ACTIVE);
        w_done_nxt  = (w_nstate == S_V_TAIL) && (w_cnt_nxt == {CNT_W{1'b0}});
        w_rd_en_nxt = ((w_nstate == S_H_BLANK) && (w_cnt_nxt == {CNT_W{1'b0}})) ||
                      ((w_nstate == S_ACTIVE)  && (w_cnt_nxt != {CNT_W{1'b0}}));
        // The first read of a frame uses the address cleared on V_LEAD entry.
        w_addr_inc  = w_rd_en_nxt &&
                      !((w_nstate == S_H_BLANK) && (w_row_nxt == {ROW_W{1'b0}}));
    end

    // Sequencer state, framing outputs, row/address counters and frame count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= {ROW_W{1'b0}};
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= {ADDR_W{1'b0}};
            r_frame_cnt <= 16'd0;
        end else begin
            r_state <= w_nstate;
            r_row   <= w_row_nxt;
            r_vsync <= w_vsync_nxt;
            r_href  <= w_href_nxt;
            r_busy  <= (w_nstate != S_IDLE);
            r_done  <= w_done_nxt;
            r_rd_en <= w_rd_en_nxt;
            if (w_nstate == S_V_LEAD) begin
                r_rd_addr <= {ADDR_W{1'b0}};
            end else if (w_addr_inc) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end else begin
                r_rd_addr <= r_rd_addr;
            end
            if (w_done_nxt) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
        end
    end

    assign per_img_vsync = r_vsync;
    assign per_img_href  = r_href;
    assign per_img_gray  = r_href ? rd_data : 8'd0;
    assign busy          = r_busy;
    assign done          = r_done;
    assign rd_en         = r_rd_en;
    assign rd_addr       = r_rd_addr;
    assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_img_stream_sequencer.sv
// Scoreboard bench for img_stream_sequencer on a 4x3 frame with data = address memory.
module tb_img_stream_sequencer;

    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              cont;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = 8'd0;
    logic              vsync;
    logic              href;
    logic [7:0]        gray;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    typedef struct {
        int len;
        bit done_exp;
    } frame_exp_t;

    logic [7:0] q_gray[$];
    int         q_addr[$];
    frame_exp_t q_frame[$];
    int         q_gap[$];

    int checks = 0;
    int errors = 0;

    img_stream_sequencer #(
        .IMG_HDISP (4),
        .IMG_VDISP (3),
        .H_BLANK   (2),
        .V_LEAD    (3),
        .V_TAIL    (1),
        .V_GAP     (2),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cont          (cont),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .per_img_vsync (vsync),
        .per_img_href  (href),
        .per_img_gray  (gray),
        .busy          (busy),
        .done          (done),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous pixel memory: data equals the low byte of the address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= rd_addr[7:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_frame(input int len, input bit done_exp, input int n_gray, input int n_addr);
        frame_exp_t f;
        f.len = len;
        f.done_exp = done_exp;
        q_frame.push_back(f);
        for (int i = 0; i < n_gray; i++) q_gray.push_back(8'(i));
        for (int i = 0; i < n_addr; i++) q_addr.push_back(i);
    endtask

    // Monitor: pops expectations whenever the DUT presents pixels, reads or frame edges.
    int  vs_run = 0;
    int  gap_run = 0;
    bit  prev_vsync = 1'b0;
    bit  prev_done = 1'b0;
    always @(negedge clk) begin
        logic [7:0] eg;
        int ea;
        frame_exp_t ef;
        int eq;
        if (href === 1'b1) begin
            if (q_gray.size() > 0) begin
                eg = q_gray.pop_front();
                chk("gray", {24'd0, gray}, {24'd0, eg});
            end else begin
                checks++; errors++;
                $display("FAIL gray_extra: unexpected pixel gray=%0d", gray);
            end
        end
        if (rd_en === 1'b1) begin
            if (q_addr.size() > 0) begin
                ea = q_addr.pop_front();
                chk("rd_addr", 32'(rd_addr), ea);
            end else begin
                checks++; errors++;
                $display("FAIL rd_extra: unexpected read addr=%0d", rd_addr);
            end
        end
        if (done === 1'b1 && vsync !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_outside_vsync: done=%0d vsync=%0d required vsync=1", done, vsync);
        end
        if (vsync === 1'b1 && !prev_vsync && gap_run > 0) begin
            if (q_gap.size() > 0) begin
                eq = q_gap.pop_front();
                chk("vgap_len", gap_run, eq);
            end else begin
                checks++; errors++;
                $display("FAIL gap_extra: unexpected busy gap of %0d cycles", gap_run);
            end
        end
        if (vsync === 1'b1) begin
            vs_run++;
            gap_run = 0;
        end else begin
            if (prev_vsync) begin
                if (q_frame.size() > 0) begin
                    ef = q_frame.pop_front();
                    chk("vsync_len", vs_run, ef.len);
                    chk("done_last", {31'd0, prev_done}, {31'd0, ef.done_exp});
                end else begin
                    checks++; errors++;
                    $display("FAIL frame_extra: unexpected frame of %0d cycles", vs_run);
                end
            end
            vs_run = 0;
            gap_run = (busy === 1'b1) ? gap_run + 1 : 0;
        end
        prev_vsync = (vsync === 1'b1);
        prev_done  = (done === 1'b1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        #1;
        chk("rst_vsync", {31'd0, vsync}, 32'd0);
        chk("rst_href", {31'd0, href}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        wait_cycles(3);
        chk("sa_busy", {31'd0, busy}, 32'd0);
        chk("sa_vsync", {31'd0, vsync}, 32'd0);

        // single frame: 22 vsync cycles, pixels 0..11, reads 0..11
        push_frame(22, 1'b1, 12, 12);
        do_start();
        chk("start_vsync", {31'd0, vsync}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        wait_cycles(30);
        chk("single_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("single_idle", {31'd0, busy}, 32'd0);

        // start while busy has no effect on timing
        push_frame(22, 1'b1, 12, 12);
        do_start();
        wait_cycles(7);
        do_start();
        wait_cycles(25);
        chk("busy_start_cnt", {16'd0, frame_cnt}, 32'd2);

        // continuous: three frames separated by 2-cycle gaps, cont dropped in frame 3
        for (int i = 0; i < 3; i++) push_frame(22, 1'b1, 12, 12);
        q_gap.push_back(2);
        q_gap.push_back(2);
        cont = 1'b1;
        do_start();
        wait_cycles(58);
        chk("cont_busy", {31'd0, busy}, 32'd1);
        cont = 1'b0;
        wait_cycles(25);
        chk("cont_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("cont_idle", {31'd0, busy}, 32'd0);

        // abort at row 1 col 2: 14 vsync cycles, pixels 0..6, reads 0..7, no done
        push_frame(14, 1'b0, 7, 8);
        do_start();
        wait_cycles(13);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_vsync", {31'd0, vsync}, 32'd0);
        chk("abort_href", {31'd0, href}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        wait_cycles(5);
        chk("abort_cnt", {16'd0, frame_cnt}, 32'd5);

        // full frame after abort restarts from address 0
        push_frame(22, 1'b1, 12, 12);
        do_start();
        wait_cycles(30);
        chk("post_abort_cnt", {16'd0, frame_cnt}, 32'd6);

        // reset mid-frame during row 0 col 1: 6 vsync cycles, pixel 0, reads 0..1
        push_frame(6, 1'b0, 1, 2);
        do_start();
        wait_cycles(6);
        rst = 1'b1;
        #1;
        chk("mrst_vsync", {31'd0, vsync}, 32'd0);
        chk("mrst_href", {31'd0, href}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("mrst_cnt", {16'd0, frame_cnt}, 32'd0);
        tick();
        rst = 1'b0;
        wait_cycles(2);
        push_frame(22, 1'b1, 12, 12);
        do_start();
        wait_cycles(30);
        chk("post_rst_cnt", {16'd0, frame_cnt}, 32'd1);

        chk("gray_left", q_gray.size(), 32'd0);
        chk("addr_left", q_addr.size(), 32'd0);
        chk("frame_left", q_frame.size(), 32'd0);
        chk("gap_left", q_gap.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
